// File: rtl/minesweeper_core.sv
// minesweeper_core: single-player minesweeper engine with a mine map loaded in IDLE,
// reveal/flag commands in PLAY and a serial 8-neighbour scan for each safe reveal.
module minesweeper_core #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_x,
    input  logic [CW-1:0] cfg_y,
    input  logic          cfg_mine,
    input  logic          start,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [CW-1:0] cmd_x,
    input  logic [CW-1:0] cmd_y,
    output logic          rsp_valid,
    output logic [1:0]    rsp_code,
    output logic [3:0]    rsp_count,
    output logic [1:0]    state,
    output logic [7:0]    mine_count,
    output logic [7:0]    flag_count
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WON = 2'b10, LOST = 2'b11} state_t;

    state_t cur, nxt;
    logic [N-1:0] mine, rev, flag;
    logic busy, op;
    logic [3:0] step, acc;
    logic [CW-1:0] cx, cy;
    logic [8:0] rev_total;
    logic cfg_ok, cmd_ok, n_ok, n_mine, hs, err, flg, nop, hit, safe, last, win;
    logic [IW-1:0] cfg_idx, cidx, nidx;
    int dr, dc, nr, nc;

    assign state     = cur;
    assign cmd_ready = cur == PLAY && !busy && !rsp_valid;
    assign hs        = cmd_valid && cmd_ready;

    always_comb begin
        cfg_ok  = int'(cfg_x) < ROWS && int'(cfg_y) < COLS;
        cfg_idx = cfg_ok ? IW'(int'(cfg_x) * COLS + int'(cfg_y)) : '0;
        cmd_ok  = int'(cx) < ROWS && int'(cy) < COLS;
        cidx    = cmd_ok ? IW'(int'(cx) * COLS + int'(cy)) : '0;
        // neighbour order NW,N,NE,W,E,SW,S,SE indexed by step 0..7
        dr      = step < 3 ? -1 : step < 5 ? 0 : 1;
        dc      = step < 3 ? int'(step) - 1 : step == 3 ? -1 : step == 4 ? 1 : int'(step) - 6;
        nr      = int'(cx) + dr;
        nc      = int'(cy) + dc;
        n_ok    = nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS;
        nidx    = n_ok ? IW'(nr * COLS + nc) : '0;
        n_mine  = n_ok && mine[nidx];
        err     = !cmd_ok;
        flg     = cmd_ok && op && !rev[cidx];
        nop     = cmd_ok && (op ? rev[cidx] : (rev[cidx] || flag[cidx]));
        hit     = cmd_ok && !op && !rev[cidx] && !flag[cidx] && mine[cidx];
        safe    = cmd_ok && !op && !rev[cidx] && !flag[cidx] && !mine[cidx];
        last    = busy && step == 4'd8;
        win     = last && (rev_total + 9'd1 == 9'(N) - {1'b0, mine_count});
    end

    always_comb begin
        nxt = cur;
        if (cur == IDLE && start && mine_count != 8'd0 && int'(mine_count) != N)
            nxt = PLAY;
        if (cur == PLAY && busy && step == 4'd0 && hit)
            nxt = LOST;
        if (cur == PLAY && win)
            nxt = WON;
        if ((cur == WON || cur == LOST) && start)
            nxt = IDLE;
    end

    always_ff @(posedge clk)
        if (rst) cur <= IDLE;
        else     cur <= nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mine       <= '0;
            rev        <= '0;
            flag       <= '0;
            mine_count <= '0;
            flag_count <= '0;
            rev_total  <= '0;
            busy       <= 1'b0;
            op         <= 1'b0;
            step       <= '0;
            acc        <= '0;
            cx         <= '0;
            cy         <= '0;
            rsp_valid  <= 1'b0;
            rsp_code   <= '0;
            rsp_count  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_code  <= '0;
            rsp_count <= '0;
            if (cur == IDLE && cfg_we && cfg_ok) begin
                mine[cfg_idx] <= cfg_mine;
                mine_count    <= mine_count + 8'(cfg_mine && !mine[cfg_idx])
                                            - 8'(!cfg_mine && mine[cfg_idx]);
            end
            if ((cur == WON || cur == LOST) && start) begin
                rev        <= '0;
                flag       <= '0;
                flag_count <= '0;
                rev_total  <= '0;
            end
            if (hs) begin
                busy <= 1'b1;
                step <= '0;
                acc  <= '0;
                op   <= cmd_op;
                cx   <= cmd_x;
                cy   <= cmd_y;
            end
            if (busy) begin
                if (step == 4'd0 && !safe) begin
                    busy      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_code  <= err ? 2'b11 : hit ? 2'b01 : nop ? 2'b10 : 2'b00;
                    if (flg) begin
                        flag[cidx] <= !flag[cidx];
                        flag_count <= flag[cidx] ? flag_count - 8'd1 : flag_count + 8'd1;
                    end
                end else if (last) begin
                    busy      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_count <= acc;
                    rev[cidx] <= 1'b1;
                    rev_total <= rev_total + 9'd1;
                end else begin
                    acc  <= acc + 4'(n_mine);
                    step <= step + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_minesweeper_core.sv
// tb_minesweeper_core: scoreboard bench driving an 8x8 and a 2x2 core over shared
// coordinate/command buses; expected responses are queued per core at issue time.
module tb_minesweeper_core;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic cfg_we1 = 0, cfg_we2 = 0, start1 = 0, start2 = 0, cfg_mine = 0;
    logic cmd_valid = 0, cmd_op = 0;
    logic [3:0] cfg_x = 0, cfg_y = 0, cmd_x = 0, cmd_y = 0;
    logic rdy1, rv1, rdy2, rv2;
    logic [1:0] rc1, st1, rc2, st2;
    logic [3:0] rn1, rn2;
    logic [7:0] mc1, fc1, mc2, fc2;

    int vectors = 0, miscompares = 0, spur = 0;
    logic [5:0] q1[$], q2[$];
    logic [5:0] e1, e2;

    minesweeper_core #(.ROWS(8), .COLS(8), .CW(4)) u1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we1), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_mine(cfg_mine), .start(start1), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .rsp_valid(rv1), .rsp_code(rc1),
        .rsp_count(rn1), .state(st1), .mine_count(mc1), .flag_count(fc1));

    minesweeper_core #(.ROWS(2), .COLS(2), .CW(4)) u2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_mine(cfg_mine), .start(start2), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .rsp_valid(rv2), .rsp_code(rc2),
        .rsp_count(rn2), .state(st2), .mine_count(mc2), .flag_count(fc2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) spur++;
            else begin
                e1 = q1.pop_front();
                check("rsp8x8 {code,count}", {rc1, rn1}, e1);
            end
        end

    always @(negedge clk)
        if (rv2 === 1'b1) begin
            if (q2.size() == 0) spur++;
            else begin
                e2 = q2.pop_front();
                check("rsp2x2 {code,count}", {rc2, rn2}, e2);
            end
        end

    task automatic cfg(input logic s, input int x, input int y, input logic m);
        cfg_x = 4'(x); cfg_y = 4'(y); cfg_mine = m;
        if (s) cfg_we2 = 1; else cfg_we1 = 1;
        @(negedge clk);
        cfg_we1 = 0; cfg_we2 = 0;
    endtask

    task automatic pulse_start(input logic s);
        if (s) start2 = 1; else start1 = 1;
        @(negedge clk);
        start1 = 0; start2 = 0;
    endtask

    task automatic issue(input logic s, input logic op, input int x, input int y,
                         input logic [1:0] code, input logic [3:0] cnt, input int lat,
                         input logic [1:0] st, input logic push);
        int n;
        n = 0;
        while (!(s ? rdy2 : rdy1) && n < 50) begin @(negedge clk); n++; end
        check("ready_before_cmd", s ? rdy2 : rdy1, 1);
        cmd_op = op; cmd_x = 4'(x); cmd_y = 4'(y); cmd_valid = 1;
        if (push) begin
            if (s) q2.push_back({code, cnt}); else q1.push_back({code, cnt});
        end
        @(negedge clk);
        cmd_valid = 0;
        if (push) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(s ? rv2 : rv1) && n < 20);
            check("rsp_latency", n, lat);
            check("state_at_rsp", s ? st2 : st1, st);
            check("ready_at_rsp", s ? rdy2 : rdy1, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", st1, 0);
        check("rst_ready", rdy1, 0);
        check("rst_rsp_valid", rv1, 0);
        check("rst_rsp_code", rc1, 0);
        check("rst_rsp_count", rn1, 0);
        check("rst_mine_count", mc1, 0);
        check("rst_flag_count", fc1, 0);
        rst = 0;
        @(negedge clk);

        // 2x2 board with one mine: three safe reveals win
        cfg(1, 0, 0, 1);
        check("m2_mine_count", mc2, 1);
        pulse_start(1);
        check("m2_play", st2, 1);
        issue(1, 0, 0, 1, 2'b00, 4'd1, 9, 2'b01, 1);
        issue(1, 0, 1, 0, 2'b00, 4'd1, 9, 2'b01, 1);
        issue(1, 0, 1, 1, 2'b00, 4'd1, 9, 2'b10, 1);
        pulse_start(1);
        check("m2_idle_after_win", st2, 0);
        check("m2_mine_kept", mc2, 1);

        // 8x8 board
        pulse_start(0);
        check("start_no_mines_idle", st1, 0);
        cfg(0, 0, 0, 1); cfg(0, 0, 2, 1); cfg(0, 2, 0, 1); cfg(0, 2, 2, 1);
        cfg(0, 0, 0, 1); cfg(0, 9, 0, 1); cfg(0, 5, 5, 1); cfg(0, 5, 5, 0);
        check("mine_count_4", mc1, 4);
        pulse_start(0);
        check("play", st1, 1);
        check("ready_in_play", rdy1, 1);
        cfg(0, 6, 6, 1);
        check("cfg_in_play_ignored", mc1, 4);
        pulse_start(0);
        check("start_in_play_ignored", st1, 1);
        issue(0, 0, 1, 1, 2'b00, 4'd4, 9, 2'b01, 1);
        issue(0, 0, 1, 1, 2'b10, 4'd0, 1, 2'b01, 1);
        issue(0, 0, 0, 1, 2'b00, 4'd2, 9, 2'b01, 1);
        issue(0, 0, 9, 0, 2'b11, 4'd0, 1, 2'b01, 1);
        issue(0, 0, 0, 8, 2'b11, 4'd0, 1, 2'b01, 1);
        issue(0, 1, 3, 3, 2'b00, 4'd0, 1, 2'b01, 1);
        check("flag_count_1", fc1, 1);
        issue(0, 0, 3, 3, 2'b10, 4'd0, 1, 2'b01, 1);
        issue(0, 1, 3, 3, 2'b00, 4'd0, 1, 2'b01, 1);
        check("flag_count_0", fc1, 0);
        issue(0, 1, 1, 1, 2'b10, 4'd0, 1, 2'b01, 1);
        issue(0, 1, 5, 5, 2'b00, 4'd0, 1, 2'b01, 1);
        check("flag_count_again", fc1, 1);
        issue(0, 0, 0, 2, 2'b01, 4'd0, 1, 2'b11, 1);
        repeat (3) @(negedge clk);
        check("lost_ready_low", rdy1, 0);
        check("lost_state", st1, 3);
        pulse_start(0);
        check("restart_idle", st1, 0);
        check("restart_flags_cleared", fc1, 0);
        check("restart_mines_kept", mc1, 4);
        pulse_start(0);
        check("replay", st1, 1);
        issue(0, 0, 1, 1, 2'b00, 4'd4, 9, 2'b01, 1);

        // reset during scan: command aborted, no response expected
        issue(0, 0, 4, 4, 2'b00, 4'd0, 0, 2'b01, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_scan_state", st1, 0);
        check("rst_scan_mines", mc1, 0);
        repeat (15) @(negedge clk);
        check("spurious_rsp", spur, 0);
        check("pending_rsp", q1.size() + q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/minesweeper_core.md
MINESWEEPER_CORE -- requirements
Module: minesweeper_core

Interface
REQ-001 Parameter ROWS, default 8, board rows (2..16).
REQ-002 Parameter COLS, default 8, board columns (2..16).
REQ-003 Parameter CW, default 4, coordinate width; must satisfy 2^CW >= max(ROWS,COLS).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  mine-map write strobe (honoured in IDLE only).
REQ-007 cfg_x, cfg_y  in  CW each  mine-map write coordinate (row, column).
REQ-008 cfg_mine  in  1  value written: 1 = mine, 0 = clear.
REQ-009 start  in  1  single-cycle game start / restart pulse.
REQ-010 cmd_valid  in  1  player command valid.
REQ-011 cmd_ready  out  1  core accepts a command this cycle.
REQ-012 cmd_op  in  1  0 = reveal, 1 = flag toggle.
REQ-013 cmd_x, cmd_y  in  CW each  command coordinate.
REQ-014 rsp_valid  out  1  single-cycle response strobe.
REQ-015 rsp_code  out  2  00 OK, 01 MINE, 10 NOP, 11 ERR.
REQ-016 rsp_count  out  4  adjacent-mine count (0..8), valid with reveal OK, else 0.
REQ-017 state  out  2  00 IDLE, 01 PLAY, 10 WON, 11 LOST.
REQ-018 mine_count, flag_count  out  8 each  mines in map; flags currently set.

Function
REQ-019 Per cell: mine, revealed, flagged bits; mine_count = number of set mine bits; rewriting a cell never double-counts.
REQ-020 IDLE: cfg_we with in-range coordinate updates the mine bit next cycle; out-of-range writes, and cfg_we in any other state, ignored.
REQ-021 IDLE + start: if mine_count is 0 or equals ROWS*COLS, stay IDLE; else -> PLAY next cycle.
REQ-022 cmd_ready = 1 only in PLAY with no command in progress; handshake = cmd_valid & cmd_ready on a rising edge.
REQ-023 Coordinate with cmd_x >= ROWS or cmd_y >= COLS: rsp_code ERR, one cycle after acceptance, no state change.
REQ-024 Flag toggle on unrevealed cell: invert flagged, adjust flag_count, rsp_code OK, latency 1; on revealed cell: NOP, latency 1.
REQ-025 Reveal of flagged or already-revealed cell: NOP, latency 1, no change.
REQ-026 Reveal of mine cell: rsp_code MINE, latency 1, state -> LOST in the same cycle as rsp_valid.
REQ-027 Reveal of safe cell: core scans the 8 neighbours one per cycle (fixed order NW,N,NE,W,E,SW,S,SE) for cycles T+1..T+8, off-board neighbours counted 0 but still consume a cycle; rsp_valid at T+9 with OK and count; cell marked revealed at T+9.
REQ-028 cmd_ready low from acceptance until the rsp_valid cycle inclusive.
REQ-029 revealed_total (internal) increments per OK reveal; when it reaches ROWS*COLS - mine_count, state -> WON in the same cycle as that rsp_valid.
REQ-030 WON/LOST: commands not accepted; start -> IDLE next cycle, clearing revealed and flagged bits and flag_count, mine map retained.
REQ-031 start in PLAY ignored; start coincident with a handshake in PLAY: command processed normally.
REQ-032 No flood-fill: a zero-count reveal opens only the addressed cell.

Reset
REQ-033 rst high at a clock edge: state IDLE, all mine/revealed/flagged bits 0, mine_count 0, flag_count 0, cmd_ready 0, rsp_valid 0, rsp_code 00, rsp_count 0.
REQ-034 rst mid-reveal-scan aborts the command; no rsp_valid is issued afterwards.
REQ-035 rst has priority over start, cfg_we and cmd_valid in the same cycle.

Verification
REQ-036 8x8, mines at (0,0),(0,2),(2,0),(2,2); start; reveal (1,1) -> rsp OK, count 4, rsp_valid exactly 9 cycles after handshake.
REQ-037 Same map; reveal (0,2) -> rsp MINE after 1 cycle, state 11, cmd_ready stays 0.
REQ-038 Flag (3,3) twice -> two OK rsps, flag_count 1 then 0; reveal (3,3) while flagged -> NOP.
REQ-039 2x2 board, one mine at (0,0); reveal (0,1),(1,0),(1,1) -> third rsp OK count 1 and state 10 in the same cycle; start -> IDLE, mine_count still 1.
REQ-040 Reveal (9,0) on 8x8 -> ERR after 1 cycle; cfg_we in PLAY -> mine_count unchanged; rst asserted at scan cycle T+4 -> state 00, no rsp_valid.
